// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory,
// holds the fetched instruction for decode and forms the next PC on retire.
//
// state | meaning
// ------+----------------------------------------------------------
// FETCH | request outstanding at pc, waiting for imem_rvalid
// HOLD  | instr valid for decode, waiting for retire
// ERR   | next-PC target misaligned, fetch halted until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] immext,
  input  logic [31:0] alu_result,
  input  logic        retire,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_misalign;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic        w_valid_nxt;
  logic        w_misalign_nxt;
  logic [31:0] w_pcplus4;
  logic [31:0] w_target;

  assign w_pcplus4 = r_pc + 32'd4;

  // Encoding 2'b11 is folded into the sequential case.
  always_comb begin
    w_target = w_pcplus4;
    case (pcsrc)
      2'b01:   w_target = r_pc + immext;
      2'b10:   w_target = alu_result & 32'hFFFF_FFFE;
      default: w_target = w_pcplus4;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_valid_nxt    = r_instr_valid;
    w_misalign_nxt = r_misalign;
    case (r_state)
      S_FETCH: begin
        if (imem_rvalid) begin
          w_instr_nxt = imem_rdata;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          w_valid_nxt = 1'b0;
          if (w_target[1:0] != 2'b00) begin
            w_misalign_nxt = 1'b1;
            w_state_nxt    = S_ERR;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_ERR: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_valid_nxt;
      r_misalign    <= w_misalign_nxt;
    end
  end

  assign imem_req     = (r_state == S_FETCH);
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign pcplus4      = w_pcplus4;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign misalign_err = r_misalign;

endmodule
